// File: rtl/instr_sequencer.sv
// Three-state instruction sequencer: HALT / FETCH / EXEC.
// Drives the timestep counter toward the processor controller and tracks PC and retired count.
module instr_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       step,
  input  logic       clr,
  input  logic       pc_load,
  input  logic [7:0] pc_val,
  input  logic       imem_ack,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  output logic [1:0] timestep,
  output logic       ir_load,
  output logic       halted,
  output logic       err,
  output logic [15:0] instr_cnt
);

  typedef enum logic [1:0] {HALT, FETCH, EXEC} state_t;

  state_t      state, state_nx;
  logic [1:0]  ts, ts_nx;
  logic [7:0]  pc, pc_nx;
  logic [15:0] cnt, cnt_nx;
  logic        err_q, err_nx;
  logic        one_shot, one_shot_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HALT;
      ts       <= 2'd0;
      pc       <= 8'd0;
      cnt      <= 16'd0;
      err_q    <= 1'b0;
      one_shot <= 1'b0;
    end else begin
      state    <= state_nx;
      ts       <= ts_nx;
      pc       <= pc_nx;
      cnt      <= cnt_nx;
      err_q    <= err_nx;
      one_shot <= one_shot_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    ts_nx       = ts;
    pc_nx       = pc;
    cnt_nx      = cnt;
    err_nx      = err_q;
    one_shot_nx = one_shot;
    case (state)
      HALT: begin
        ts_nx = 2'd0;
        // run wins over step, so a simultaneous step does not arm a single-shot
        if (run) begin
          state_nx = FETCH;
        end else if (step) begin
          state_nx    = FETCH;
          one_shot_nx = 1'b1;
        end
      end
      FETCH: begin
        ts_nx = 2'd0;
        if (imem_ack) begin
          state_nx = EXEC;
          ts_nx    = 2'd1;
        end
      end
      EXEC: begin
        if (clr) begin
          ts_nx       = 2'd0;
          pc_nx       = pc + 8'd1;
          cnt_nx      = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
          state_nx    = (run && !one_shot) ? FETCH : HALT;
          one_shot_nx = 1'b0;
        end else if (ts == 2'd3) begin
          // controller never retired: abort without committing anything
          ts_nx       = 2'd0;
          err_nx      = 1'b1;
          state_nx    = HALT;
          one_shot_nx = 1'b0;
        end else begin
          ts_nx = ts + 2'd1;
        end
      end
      default: begin
        state_nx = HALT;
        ts_nx    = 2'd0;
      end
    endcase
    if (pc_load) pc_nx = pc_val;
  end

  assign imem_req  = (state == FETCH);
  assign ir_load   = (state == FETCH) && imem_ack;
  assign halted    = (state == HALT);
  assign imem_addr = pc;
  assign timestep  = ts;
  assign err       = err_q;
  assign instr_cnt = cnt;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: inputs driven and outputs sampled on the falling edge.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, run, step, clr, pc_load, imem_ack;
  logic [7:0]  pc_val;
  logic        imem_req, ir_load, halted, err;
  logic [7:0]  imem_addr;
  logic [1:0]  timestep;
  logic [15:0] instr_cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instr_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .clr(clr),
    .pc_load(pc_load), .pc_val(pc_val), .imem_ack(imem_ack),
    .imem_req(imem_req), .imem_addr(imem_addr), .timestep(timestep),
    .ir_load(ir_load), .halted(halted), .err(err), .instr_cnt(instr_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},    imem_req,  0);
    chk({tag, "_ts"},     timestep,  0);
    chk({tag, "_addr"},   imem_addr, 0);
    chk({tag, "_irl"},    ir_load,   0);
    chk({tag, "_halted"}, halted,    1);
    chk({tag, "_err"},    err,       0);
    chk({tag, "_cnt"},    instr_cnt, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; run = 0; step = 0; clr = 0; pc_load = 0; pc_val = 0; imem_ack = 0;
    #3;
    chk_reset_vals("rst");
    cyc();
    rst_n = 1'b1;

    // basic run: ack on first fetch cycle, retire at ts=1
    run = 1; imem_ack = 1;
    cyc();
    chk("t1_req", imem_req, 1);
    chk("t1_addr", imem_addr, 8'h00);
    #1 chk("t1_irl", ir_load, 1);
    cyc(); imem_ack = 0;
    chk("t1_ts1", timestep, 1);
    #1 chk("t1_irl_exec", ir_load, 0);
    clr = 1;
    cyc(); clr = 0;
    chk("t1_ts0", timestep, 0);
    chk("t1_addr1", imem_addr, 8'h01);
    chk("t1_cnt", instr_cnt, 1);
    chk("t1_refetch", imem_req, 1);
    // drop run mid-instruction: finishes, then halts
    run = 0; imem_ack = 1;
    cyc(); imem_ack = 0; clr = 1;
    chk("t1b_exec", timestep, 1);
    cyc(); clr = 0;
    chk("t1b_halt", halted, 1);
    chk("t1b_cnt", instr_cnt, 2);
    chk("t1b_addr", imem_addr, 8'h02);

    // single step, ack delayed, 3-cycle instruction
    do_reset();
    step = 1;
    cyc(); step = 0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t2_req%0d", k), imem_req, 1);
      chk($sformatf("t2_ts%0d", k), timestep, 0);
      if (k == 3) begin
        imem_ack = 1;
        #1 chk("t2_irl", ir_load, 1);
      end else begin
        #1 chk($sformatf("t2_noirl%0d", k), ir_load, 0);
      end
      cyc();
    end
    imem_ack = 0;
    chk("t2_ts1", timestep, 1);
    chk("t2_noreq", imem_req, 0);
    cyc(); chk("t2_ts2", timestep, 2);
    cyc(); chk("t2_ts3", timestep, 3);
    clr = 1;
    cyc(); clr = 0;
    chk("t2_ts_end", timestep, 0);
    chk("t2_halt", halted, 1);
    chk("t2_pc", imem_addr, 8'h01);
    // ack and clr in HALT are ignored
    imem_ack = 1; clr = 1;
    #1 chk("t2_halt_irl", ir_load, 0);
    cyc(); imem_ack = 0; clr = 0;
    chk("t2_halt_stay", halted, 1);
    chk("t2_halt_cnt", instr_cnt, 1);

    // PC wrap and pc_load vs retire
    pc_load = 1; pc_val = 8'hFF;
    cyc(); pc_load = 0;
    chk("t3_ld", imem_addr, 8'hFF);
    run = 1;
    cyc(); imem_ack = 1;
    cyc(); imem_ack = 0; clr = 1;
    cyc(); clr = 0;
    chk("t3_wrap", imem_addr, 8'h00);
    chk("t3_cnt2", instr_cnt, 2);
    imem_ack = 1;
    cyc(); imem_ack = 0; clr = 1; pc_load = 1; pc_val = 8'h20;
    cyc(); clr = 0; pc_load = 0;
    chk("t3_ldwin", imem_addr, 8'h20);
    chk("t3_cnt3", instr_cnt, 3);
    chk("t3_fetch", imem_req, 1);
    // pc_load during an outstanding fetch
    pc_load = 1; pc_val = 8'h40;
    cyc(); pc_load = 0;
    chk("t3_fld_addr", imem_addr, 8'h40);
    chk("t3_fld_req", imem_req, 1);
    cyc();
    chk("t3_fld_hold", imem_addr, 8'h40);
    chk("t3_fld_req2", imem_req, 1);

    // timestep overrun -> err
    run = 0; imem_ack = 1;
    cyc(); imem_ack = 0;
    cyc(); cyc();
    chk("t4_ts3", timestep, 3);
    cyc();
    chk("t4_ts0", timestep, 0);
    chk("t4_err", err, 1);
    chk("t4_halt", halted, 1);
    chk("t4_pc", imem_addr, 8'h40);
    chk("t4_cnt", instr_cnt, 3);
    cyc(); cyc();
    chk("t4_sticky", err, 1);

    // async reset mid-fetch
    run = 1;
    cyc();
    chk("t5_req", imem_req, 1);
    #2 rst_n = 0; imem_ack = 1;
    #1 chk_reset_vals("t5");
    cyc(); cyc();
    chk("t5_irl_in_rst", ir_load, 0);
    chk("t5_still_halt", halted, 1);
    imem_ack = 0; run = 0;
    #2 rst_n = 1;

    // run + step together: continuous
    cyc();
    run = 1; step = 1;
    cyc(); step = 0; imem_ack = 1;
    cyc(); imem_ack = 0; clr = 1;
    cyc(); clr = 0;
    chk("t6_cont_req", imem_req, 1);
    chk("t6_cont_halt", halted, 0);
    imem_ack = 1;
    cyc(); imem_ack = 0; clr = 1;
    cyc(); clr = 0;
    chk("t6_cont2", imem_req, 1);
    chk("t6_cnt", instr_cnt, 2);
    chk("t6_addr", imem_addr, 8'h02);
    run = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
